// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Brief    : Shared encodings for the instruction-fetch stage: jump-select
//             codes from decode, fetch FSM states and the bubble instruction.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

  // sig_jump_d encodings; 2'b11 is not produced by decode and acts as none
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JR   = 2'b10;

  // sll $0,$0,0 -- the canonical MIPS no-op
  localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

  // FETCH: request outstanding; HELD: response buffered during a stall;
  // DROP: response still in flight for an address that has been squashed
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HELD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_redirect_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_redirect_sel
//  Brief    : Decides whether decode redirects the fetch stream this cycle
//             and selects the new PC (jr > j/jal > taken branch).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_redirect_sel
  import fetch_stage_pkg::*;
(
  input  logic        stall_d,
  input  logic        pc_src_d,
  input  logic [1:0]  sig_jump_d,
  input  logic [31:0] branch_target_d,
  input  logic [31:0] jump_target_d,
  input  logic [31:0] jr_target_d,
  output logic        redirect,
  output logic [31:0] target
);

  // A stalled decode will re-present its branch, so no redirect is taken now
  always_comb begin
    redirect = 1'b0;
    target   = branch_target_d;
    unique case (sig_jump_d)
      JUMP_JR: begin
        redirect = 1'b1;
        target   = jr_target_d;
      end
      JUMP_J: begin
        redirect = 1'b1;
        target   = jump_target_d;
      end
      default: begin
        redirect = pc_src_d;
        target   = branch_target_d;
      end
    endcase
    if (stall_d) begin
      redirect = 1'b0;
    end
  end

endmodule : fetch_redirect_sel
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : MIPS instruction-fetch stage. Owns the PC, the instruction
//             memory request handshake and the IF/ID pipeline register.
//             Copes with variable memory latency by inserting bubbles and
//             buffering one returned instruction across a stall.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        pc_src_d,
  input  logic [31:0] branch_target_d,
  input  logic [1:0]  sig_jump_d,
  input  logic [31:0] jump_target_d,
  input  logic [31:0] jr_target_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d_n;
  logic [31:0] pc_plus4_q, pc_plus4_d_n;
  logic        valid_q, valid_d_n;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_plus4_q, buf_pc_plus4_d;
  logic [31:0] pending_q, pending_d;

  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_stall    = stall_f | stall_d;
  assign w_pc_plus4 = pc_q + 32'd4;

  fetch_redirect_sel u_redirect_sel (
    .stall_d         (stall_d),
    .pc_src_d        (pc_src_d),
    .sig_jump_d      (sig_jump_d),
    .branch_target_d (branch_target_d),
    .jump_target_d   (jump_target_d),
    .jr_target_d     (jr_target_d),
    .redirect        (w_redirect),
    .target          (w_target)
  );

  // State register plus PC, IF/ID, fetch buffer and pending-target flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      instr_q        <= NOP_INSTR;
      pc_plus4_q     <= 32'd0;
      valid_q        <= 1'b0;
      buf_instr_q    <= NOP_INSTR;
      buf_pc_plus4_q <= 32'd0;
      pending_q      <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d_n;
      pc_plus4_q     <= pc_plus4_d_n;
      valid_q        <= valid_d_n;
      buf_instr_q    <= buf_instr_d;
      buf_pc_plus4_q <= buf_pc_plus4_d;
      pending_q      <= pending_d;
    end
  end

  // Next-state: track whether a response is awaited, buffered or squashed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          if (!w_redirect && w_stall) begin
            state_d = ST_HELD;
          end
        end else if (w_redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_HELD: begin
        if (w_redirect || !w_stall) begin
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (imem_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath: PC update, IF/ID load or bubble, buffer capture, pending target
  always_comb begin
    pc_d           = pc_q;
    instr_d_n      = instr_q;
    pc_plus4_d_n   = pc_plus4_q;
    valid_d_n      = valid_q;
    buf_instr_d    = buf_instr_q;
    buf_pc_plus4_d = buf_pc_plus4_q;
    pending_d      = pending_q;

    unique case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          if (w_redirect) begin
            // No delay slot: the word just returned is squashed
            pc_d         = w_target;
            instr_d_n    = NOP_INSTR;
            pc_plus4_d_n = 32'd0;
            valid_d_n    = 1'b0;
          end else if (w_stall) begin
            buf_instr_d    = imem_rdata;
            buf_pc_plus4_d = w_pc_plus4;
          end else begin
            instr_d_n    = imem_rdata;
            pc_plus4_d_n = w_pc_plus4;
            valid_d_n    = 1'b1;
            pc_d         = w_pc_plus4;
          end
        end else begin
          // Response not back yet; the address it answers is kept on the bus
          if (w_redirect) begin
            pending_d = w_target;
          end
          if (!stall_d) begin
            instr_d_n    = NOP_INSTR;
            pc_plus4_d_n = 32'd0;
            valid_d_n    = 1'b0;
          end
        end
      end
      ST_HELD: begin
        if (w_redirect) begin
          pc_d         = w_target;
          instr_d_n    = NOP_INSTR;
          pc_plus4_d_n = 32'd0;
          valid_d_n    = 1'b0;
        end else if (!w_stall) begin
          instr_d_n    = buf_instr_q;
          pc_plus4_d_n = buf_pc_plus4_q;
          valid_d_n    = 1'b1;
          pc_d         = w_pc_plus4;
        end
      end
      ST_DROP: begin
        // A later redirect supersedes the one still waiting on the bus
        if (w_redirect) begin
          pending_d = w_target;
        end
        if (imem_ready) begin
          pc_d = w_redirect ? w_target : pending_q;
        end
        if (!stall_d) begin
          instr_d_n    = NOP_INSTR;
          pc_plus4_d_n = 32'd0;
          valid_d_n    = 1'b0;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Outputs: request whenever a response is expected; held fetches idle the bus
  always_comb begin
    imem_req   = ((state_q == ST_FETCH) || (state_q == ST_DROP)) && !reset;
    imem_addr  = pc_q;
    pc_f       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
  end

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Directed self-checking bench for fetch_stage. Instruction
//             memory returns {16'hC0DE, addr[15:0]}, either in the request
//             cycle (zero-wait) or when the bench pulses a ready flag.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        stall_d;
  logic        pc_src_d;
  logic [31:0] branch_target_d;
  logic [1:0]  sig_jump_d;
  logic [31:0] jump_target_d;
  logic [31:0] jr_target_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  logic        zero_wait;
  logic        man_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_ready = zero_wait ? imem_req : man_ready;
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .pc_src_d        (pc_src_d),
    .branch_target_d (branch_target_d),
    .sig_jump_d      (sig_jump_d),
    .jump_target_d   (jump_target_d),
    .jr_target_d     (jr_target_d),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .pc_f            (pc_f),
    .instr_d         (instr_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] i, input logic [31:0] p, input logic v);
    check({tag, ".instr_d"},    instr_d,           i);
    check({tag, ".pc_plus4_d"}, pc_plus4_d,        p);
    check({tag, ".valid_d"},    {31'd0, valid_d},  {31'd0, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    stall_f         = 1'b0;
    stall_d         = 1'b0;
    pc_src_d        = 1'b0;
    branch_target_d = 32'd0;
    sig_jump_d      = 2'b00;
    jump_target_d   = 32'd0;
    jr_target_d     = 32'd0;
    zero_wait       = 1'b1;
    man_ready       = 1'b0;

    // Reset state
    step();
    step();
    check("rst.pc_f", pc_f, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.imem_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_rel.imem_req", {31'd0, imem_req}, 32'd1);
    check("rst_rel.imem_addr", imem_addr, 32'h0);

    // Zero-wait streaming: one instruction per cycle
    step();
    check_ifid("zw0", 32'hC0DE_0000, 32'h4, 1'b1);
    check("zw0.pc_f", pc_f, 32'h4);
    step();
    check_ifid("zw1", 32'hC0DE_0004, 32'h8, 1'b1);
    step();
    check_ifid("zw2", 32'hC0DE_0008, 32'hC, 1'b1);
    step();
    check("zw3.pc_f", pc_f, 32'h10);

    // Ready delayed three cycles at 0x10: three bubbles then the word
    zero_wait = 1'b0;
    man_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("lat_bubble", 32'h0, 32'h0, 1'b0);
      check("lat_bubble.pc_f", pc_f, 32'h10);
    end
    check("lat.imem_addr", imem_addr, 32'h10);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    check_ifid("lat_done", 32'hC0DE_0010, 32'h14, 1'b1);
    check("lat_done.pc_f", pc_f, 32'h14);

    // Response arrives during a two-cycle stall: buffered, bus idle
    stall_f   = 1'b1;
    stall_d   = 1'b1;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    check_ifid("held0", 32'hC0DE_0010, 32'h14, 1'b1);
    check("held0.imem_req", {31'd0, imem_req}, 32'd0);
    step();
    check_ifid("held1", 32'hC0DE_0010, 32'h14, 1'b1);
    check("held1.imem_req", {31'd0, imem_req}, 32'd0);
    stall_f = 1'b0;
    stall_d = 1'b0;
    step();
    check_ifid("held_rel", 32'hC0DE_0014, 32'h18, 1'b1);
    check("held_rel.imem_addr", imem_addr, 32'h18);
    check("held_rel.imem_req", {31'd0, imem_req}, 32'd1);

    // Advance to 0x24, then take a branch while that fetch is outstanding
    zero_wait = 1'b1;
    step();
    step();
    step();
    check("pre_drop.pc_f", pc_f, 32'h24);
    check("pre_drop.instr_d", instr_d, 32'hC0DE_0020);
    zero_wait       = 1'b0;
    man_ready       = 1'b0;
    pc_src_d        = 1'b1;
    branch_target_d = 32'h40;
    step();
    pc_src_d = 1'b0;
    check("drop.imem_addr", imem_addr, 32'h24);
    check("drop.imem_req", {31'd0, imem_req}, 32'd1);
    check("drop.valid_d", {31'd0, valid_d}, 32'd0);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    check("drop_done.imem_addr", imem_addr, 32'h40);
    check_ifid("drop_done", 32'h0, 32'h0, 1'b0);
    zero_wait = 1'b1;
    step();
    check_ifid("after_drop", 32'hC0DE_0040, 32'h44, 1'b1);

    // jr beats a simultaneous taken branch; stall_d suppresses the redirect
    sig_jump_d      = 2'b10;
    jr_target_d     = 32'h80;
    pc_src_d        = 1'b1;
    branch_target_d = 32'h40;
    jump_target_d   = 32'h60;
    step();
    check("prio.pc_f", pc_f, 32'h80);
    check("prio.valid_d", {31'd0, valid_d}, 32'd0);
    stall_d = 1'b1;
    step();
    check("prio_stall.pc_f", pc_f, 32'h80);
    check("prio_stall.imem_req", {31'd0, imem_req}, 32'd0);
    check_ifid("prio_stall", 32'h0, 32'h0, 1'b0);
    stall_d    = 1'b0;
    sig_jump_d = 2'b01;
    pc_src_d   = 1'b0;
    step();
    check("jump.pc_f", pc_f, 32'h60);
    check("jump.valid_d", {31'd0, valid_d}, 32'd0);
    sig_jump_d = 2'b11;
    step();
    check_ifid("jump11", 32'hC0DE_0060, 32'h64, 1'b1);
    check("jump11.pc_f", pc_f, 32'h64);

    // PC wraps from 0xFFFF_FFFC to 0
    sig_jump_d    = 2'b01;
    jump_target_d = 32'hFFFF_FFFC;
    step();
    check("wrap_pre.pc_f", pc_f, 32'hFFFF_FFFC);
    sig_jump_d = 2'b00;
    step();
    check_ifid("wrap", 32'hC0DE_FFFC, 32'h0, 1'b1);
    check("wrap.pc_f", pc_f, 32'h0);

    // Reset while in DROP
    step();
    check("rdrop_pre.pc_f", pc_f, 32'h4);
    zero_wait       = 1'b0;
    man_ready       = 1'b0;
    pc_src_d        = 1'b1;
    branch_target_d = 32'h100;
    step();
    pc_src_d = 1'b0;
    reset    = 1'b1;
    #1;
    check("rdrop.imem_req_in_rst", {31'd0, imem_req}, 32'd0);
    step();
    check("rdrop.pc_f", pc_f, 32'h0);
    check("rdrop.valid_d", {31'd0, valid_d}, 32'd0);
    check("rdrop.imem_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    check("rdrop_rel.imem_req", {31'd0, imem_req}, 32'd1);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    check_ifid("rdrop_fetch", 32'hC0DE_0000, 32'h4, 1'b1);

    // Reset while in HELD
    stall_f   = 1'b1;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    check("rheld_pre.imem_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    step();
    check("rheld.pc_f", pc_f, 32'h0);
    check("rheld.valid_d", {31'd0, valid_d}, 32'd0);
    check("rheld.imem_req", {31'd0, imem_req}, 32'd0);
    reset   = 1'b0;
    stall_f = 1'b0;
    #1;
    check("rheld_rel.imem_req", {31'd0, imem_req}, 32'd1);
    zero_wait = 1'b1;
    step();
    check_ifid("rheld_fetch", 32'hC0DE_0000, 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes stall_f/stall_d from the hazard unit and branch/jump redirects resolved in decode.
- Produces instr_d and pc_plus4_d for the decode stage.
- Tolerates variable-latency instruction memory by inserting bubbles and buffering one returned instruction while stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID on a bubble (sll $0,$0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_f  in  1  hazard unit: hold PC / hold buffered fetch
stall_d  in  1  hazard unit: hold IF/ID register
pc_src_d  in  1  conditional branch taken in decode
branch_target_d  in  32  branch target address
sig_jump_d  in  2  00 none, 01 j/jal, 10 jr, 11 treated as none
jump_target_d  in  32  j/jal target
jr_target_d  in  32  forwarded rs value for jr
imem_req  out  1  request valid
imem_addr  out  32  request address (= pc_f)
imem_rdata  in  32  returned instruction word
imem_ready  in  1  one-cycle pulse: imem_rdata valid, request complete
pc_f  out  32  current fetch PC
instr_d  out  32  IF/ID instruction
pc_plus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (sync, high): pc_f=RESET_PC, instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0, state=FETCH, buffer cleared. imem_req=0 while reset is high. Any outstanding request is abandoned; imem shares the same reset.
- stall = stall_f | stall_d; both are treated as one hold.
- redirect = !stall_d & (sig_jump_d==10 | sig_jump_d==01 | pc_src_d). A redirect is ignored while stall_d=1; the stalled branch is re-presented.
- Target priority: jr_target_d (10) > jump_target_d (01) > branch_target_d.
- No delay slot: the instruction fetched after a taken redirect is squashed.
- imem_req = (state==FETCH | state==DROP) & !reset. imem_addr = pc_f, stable until imem_ready. Exactly one response per request.
- Bubble = {instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0}. IF/ID changes only when stall_d=0.
- FETCH:
  - ready & redirect: discard rdata; pc_f<=target; IF/ID<=bubble; stay FETCH.
  - ready & stall: buffer {rdata, pc_f+4}; go HELD; IF/ID unchanged.
  - ready & !stall: IF/ID<={rdata, pc_f+4, 1}; pc_f<=pc_f+4.
  - !ready & redirect: pending<=target; IF/ID<=bubble; go DROP.
  - !ready & !stall_d: IF/ID<=bubble.
  - !ready & stall_d: hold.
- HELD (imem_req=0):
  - redirect: drop buffer; pc_f<=target; IF/ID<=bubble; go FETCH.
  - !stall: IF/ID<=buffer with valid 1; pc_f<=pc_f+4; go FETCH.
  - otherwise hold.
- DROP (response in flight for a squashed address):
  - !ready: IF/ID<=bubble if !stall_d. A new redirect overwrites pending.
  - ready: discard rdata; pc_f<=pending (or the new target if a redirect arrives the same cycle); IF/ID<=bubble if !stall_d; go FETCH.
- Latency: zero-wait memory (ready in the request cycle) gives 1 instruction/cycle. instr_d is valid the cycle after imem_ready.
- PC arithmetic is 32-bit unsigned wrap: 32'hFFFF_FFFC + 4 = 0. Low two address bits pass through unchecked.

Decomposition:
- Shared package: sig_jump_d encodings (JUMP_NONE/J/JR), fetch state enum (FETCH, HELD, DROP), NOP_INSTR constant.
- One sub-module: fetch_redirect_sel, a combinational block that computes redirect and target from stall_d, pc_src_d, sig_jump_d and the three targets.

Test Plan:
- Zero-wait memory, no stalls, RESET_PC=0: instr_d sequence matches words at 0,4,8; pc_plus4_d=4,8,12; valid_d=1 from the 2nd cycle after reset drops.
- imem_ready delayed 3 cycles at pc 0x10, stall_d=0: 3 bubbles (valid_d=0, instr_d=NOP); then instr_d=mem[0x10], pc_plus4_d=0x14.
- imem_ready arrives with stall_f=stall_d=1 for 2 cycles: IF/ID unchanged, imem_req=0 during HELD; on release instr_d=buffered word, next imem_addr=pc+4.
- Taken branch (pc_src_d=1, target 0x40) while the fetch at 0x24 is outstanding: state DROP, ready discarded, next imem_addr=0x40, IF/ID bubble, mem[0x24] never reaches valid_d=1.
- sig_jump_d=10 with jr_target_d=0x80 and pc_src_d=1 with branch_target_d=0x40 in the same cycle: next imem_addr=0x80. The same inputs with stall_d=1: no redirect.
- Reset asserted in DROP and in HELD: next cycle pc_f=RESET_PC, valid_d=0, imem_req=0 while reset is high, state FETCH.
